converter_bits_rx: RTL and testbench

Serial-to-parallel receiver for the PHY RX path. It is the counterpart of the PHY TX 8-to-1 bit serializer.
- Takes a 1-bit stream on dclk, sent MSB first, with commas 8'hBC used as idle/alignment characters.
- Finds byte alignment by hunting for the comma and locks after a run of consecutive aligned commas.
- Once locked, delivers each non-comma byte as an 8-bit word with a one-cycle valid strobe.

---
 rtl/converter_bits_rx.sv | 135 +++++++++++++
 tb/tb_converter_bits_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/converter_bits_rx.sv
// converter_bits_rx: serial-to-parallel receiver for the PHY RX path.
// Hunts for comma alignment in an MSB-first bit stream, locks after
// LOCK_COUNT consecutive aligned commas, then emits every non-comma byte.
//
// Ports:
//   dclk            bit clock, all state changes on posedge
//   default_values  asynchronous active-high reset
//   data_in         serial bit, MSB of each byte first
//   data_out        last received non-comma byte
//   valid_out       one-cycle strobe, data_out holds a new byte
//   active          high while locked
//   cnt             bit position within the current byte (0..7)
module converter_bits_rx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       dclk,
  input  logic       default_values,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [2:0] cnt
);

  localparam int unsigned CCNT_W  = 4;
  localparam logic [CCNT_W-1:0] LOCK_CNT_W = CCNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  // Only the seven most recent bits are needed to form the byte window.
  logic [6:0]        sr_q, sr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CCNT_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;

  logic [7:0]        win;
  logic              is_comma;
  logic              boundary;

  // Byte that completes with the bit currently on data_in.
  assign win      = {sr_q, data_in};
  assign is_comma = (win == COMMA);
  assign boundary = (cnt_q == 3'd7);

  // State register.
  always_ff @(posedge dclk or posedge default_values) begin
    if (default_values) begin
      state_q     <= SEARCH;
      sr_q        <= 7'h00;
      cnt_q       <= 3'd0;
      comma_cnt_q <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    sr_d        = win[6:0];
    cnt_d       = cnt_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;

    case (state_q)
      SEARCH: begin
        // A match here may straddle a true boundary; LOCKING weeds it out.
        cnt_d = 3'd0;
        if (is_comma) begin
          if (LOCK_COUNT == 32'd1) begin
            state_d = ACTIVE;
          end else begin
            comma_cnt_d = CCNT_W'(1);
            state_d     = LOCKING;
          end
        end
      end

      LOCKING: begin
        cnt_d = cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + CCNT_W'(1);
            if (comma_cnt_d == LOCK_CNT_W) begin
              state_d = ACTIVE;
            end
          end else begin
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // No loss-of-sync detection: only reset leaves ACTIVE.
        cnt_d = cnt_q + 3'd1;
        if (boundary && !is_comma) begin
          data_d  = win;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = SEARCH;
        cnt_d   = 3'd0;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_converter_bits_rx.sv
module tb_converter_bits_rx;

  logic       dclk;
  logic       default_values;
  logic       data_in;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       active_a, active_b;
  logic [2:0] cnt_a, cnt_b;

  int n_cmp;
  int n_fail;

  converter_bits_rx #(.COMMA(8'hBC), .LOCK_COUNT(4)) u_a (
    .dclk(dclk), .default_values(default_values), .data_in(data_in),
    .data_out(data_a), .valid_out(valid_a), .active(active_a), .cnt(cnt_a)
  );

  converter_bits_rx #(.COMMA(8'hBC), .LOCK_COUNT(1)) u_b (
    .dclk(dclk), .default_values(default_values), .data_in(data_in),
    .data_out(data_b), .valid_out(valid_b), .active(active_b), .cnt(cnt_b)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: index 0 is LOCK_COUNT=4, index 1 is LOCK_COUNT=1.
  localparam int M_SRCH = 0;
  localparam int M_LOCK = 1;
  localparam int M_ACT  = 2;

  int m_lc   [2] = '{4, 1};
  int m_hist [2];
  int m_mode [2];
  int m_pos  [2];
  int m_runs [2];
  int m_data [2];
  int m_valid[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = 0; m_mode[k] = M_SRCH; m_pos[k] = 0;
      m_runs[k] = 0; m_data[k] = 0; m_valid[k] = 0;
    end
  endtask

  task automatic model_step(input logic b);
    int  w;
    bit  isc;
    bit  bnd;
    for (int k = 0; k < 2; k++) begin
      w   = ((m_hist[k] << 1) | int'(b)) & 255;
      m_hist[k] = w;
      isc = (w == 'hBC);
      bnd = (m_pos[k] == 7);
      m_valid[k] = 0;
      if (m_mode[k] == M_SRCH) begin
        m_pos[k] = 0;
        if (isc) begin
          m_runs[k] = 1;
          m_mode[k] = (m_lc[k] == 1) ? M_ACT : M_LOCK;
        end
      end else if (m_mode[k] == M_LOCK) begin
        m_pos[k] = (m_pos[k] + 1) % 8;
        if (bnd) begin
          if (isc) begin
            m_runs[k]++;
            if (m_runs[k] == m_lc[k]) m_mode[k] = M_ACT;
          end else begin
            m_runs[k] = 0;
            m_mode[k] = M_SRCH;
          end
        end
      end else begin
        m_pos[k] = (m_pos[k] + 1) % 8;
        if (bnd && !isc) begin
          m_valid[k] = 1;
          m_data[k]  = w;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a.valid",  8'(valid_a),  8'(m_valid[0]));
    check("a.data",   data_a,       8'(m_data[0]));
    check("a.active", 8'(active_a), 8'(m_mode[0] == M_ACT));
    check("a.cnt",    8'(cnt_a),    8'(m_pos[0]));
    check("b.valid",  8'(valid_b),  8'(m_valid[1]));
    check("b.data",   data_b,       8'(m_data[1]));
    check("b.active", 8'(active_b), 8'(m_mode[1] == M_ACT));
    check("b.cnt",    8'(cnt_b),    8'(m_pos[1]));
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge dclk);
    model_step(b);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic apply_reset();
    default_values = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge dclk);
    #1;
    default_values = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    int         npre;
    logic [7:0] pre;
    logic [7:0] b;
    logic       ea;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, int np, logic [7:0] p, logic [7:0] b,
                              logic a, logic v, logic [7:0] d, logic [2:0] c);
    vec_t t;
    t.rst = r; t.npre = np; t.pre = p; t.b = b;
    t.ea = a; t.ev = v; t.ed = d; t.ec = c;
    return t;
  endfunction

  int r;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    data_in = 1'b0;
    default_values = 1'b1;
    model_reset();

    // Basic lock then one data byte.
    tbl.push_back(mk(1, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h5A, 1, 1, 8'h5A, 3'd0));
    // Misaligned start with filler bits 1,0,1.
    tbl.push_back(mk(1, 3, 8'h05, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h11, 1, 1, 8'h11, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 0, 8'h11, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h22, 1, 1, 8'h22, 3'd0));
    // Broken lock then relock.
    tbl.push_back(mk(1, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h77, 1, 1, 8'h77, 3'd0));
    // False comma straddling 0x0B/0xC0: LOCKING for 8 bits, then SEARCH.
    tbl.push_back(mk(1, 0, 8'h00, 8'h0B, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hC0, 0, 0, 8'h00, 3'd4));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0));

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      for (int j = tbl[i].npre - 1; j >= 0; j--) send_bit(tbl[i].pre[j]);
      send_byte(tbl[i].b);
      check($sformatf("tbl%0d.active", i), 8'(active_a), 8'(tbl[i].ea));
      check($sformatf("tbl%0d.valid",  i), 8'(valid_a),  8'(tbl[i].ev));
      check($sformatf("tbl%0d.data",   i), data_a,       tbl[i].ed);
      check($sformatf("tbl%0d.cnt",    i), 8'(cnt_a),    8'(tbl[i].ec));
    end

    // Asynchronous reset in the middle of a byte while locked.
    apply_reset();
    repeat (4) send_byte(8'hBC);
    send_byte(8'h5A);
    check("mid.pre_data", data_a, 8'h5A);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("mid.pre_cnt", 8'(cnt_a), 8'd4);
    #2;
    default_values = 1'b1;
    #1;
    model_reset();
    check("mid.async_active", 8'(active_a), 8'd0);
    check("mid.async_data",   data_a,       8'h00);
    check("mid.async_cnt",    8'(cnt_a),    8'd0);
    check("mid.async_b_act",  8'(active_b), 8'd0);
    @(posedge dclk);
    #1;
    default_values = 1'b0;
    repeat (3) send_byte(8'hBC);
    send_byte(8'h66);
    check("mid.relock3_active", 8'(active_a), 8'd0);
    check("mid.relock3_valid",  8'(valid_a),  8'd0);
    repeat (4) send_byte(8'hBC);
    send_byte(8'h66);
    check("mid.relock4_valid", 8'(valid_a), 8'd1);
    check("mid.relock4_data",  data_a,      8'h66);

    // LOCK_COUNT=1 instance: one comma is enough.
    apply_reset();
    send_byte(8'hBC);
    check("lc1.active", 8'(active_b), 8'd1);
    check("lc4.active", 8'(active_a), 8'd0);
    send_byte(8'hA5);
    check("lc1.valid", 8'(valid_b), 8'd1);
    check("lc1.data",  data_b,      8'hA5);

    // Randomized traffic with bit slips and occasional resets.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(99));
      if (r < 2)       apply_reset();
      else if (r < 7)  send_bit(1'($urandom_range(1)));
      else if (r < 50) send_byte(8'hBC);
      else             send_byte(8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
